// File: rtl/aes_192_ctrl.sv
// aes_192_ctrl: register-file front end and result buffer for the pipelined
// aes_192 engine. Word writes assemble the 192-bit key and 128-bit state,
// a go request issues a single-cycle start pulse, the engine result is held
// on a valid/ready handshake, and a watchdog abandons a stalled engine.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | registers writable; go launches an operation and clears err
// START | aes_start high for exactly this cycle
// ARM   | wait for aes_out_valid low, proving the engine took the start
// RUN   | wait for aes_out_valid high, then capture aes_out
// HOLD  | res_valid high until res_ready completes the handshake
module aes_192_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [3:0]   wr_addr,
  input  logic [31:0]  wr_data,
  output logic         wr_drop,
  input  logic         go,
  output logic         busy,
  output logic         err,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_data,
  output logic         aes_start,
  output logic [127:0] aes_state,
  output logic [191:0] aes_key,
  input  logic [127:0] aes_out,
  input  logic         aes_out_valid
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ARM   = 3'd2,
    S_RUN   = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [CW-1:0]  wd_cnt;
  logic [191:0]   key_q;
  logic [127:0]   st_q;
  logic [127:0]   res_q;
  logic           err_q;
  logic           drop_q;

  logic           idle;
  logic           launch;
  logic           in_wait;
  logic           wd_hit;
  logic           capture;

  assign idle    = (state_q == S_IDLE);
  assign launch  = idle && go;
  assign in_wait = (state_q == S_ARM) || (state_q == S_RUN);
  // The counter is about to reach TIMEOUT, so this is the last cycle
  // allowed in ARM+RUN.
  assign wd_hit  = in_wait && (wd_cnt == CW'(TIMEOUT - 1));
  // A timeout in the same cycle as completion wins: nothing is captured.
  assign capture = (state_q == S_RUN) && aes_out_valid && !wd_hit;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (go) state_d = S_START;
      S_START: state_d = S_ARM;
      S_ARM: begin
        if (wd_hit)              state_d = S_IDLE;
        else if (!aes_out_valid) state_d = S_RUN;
      end
      S_RUN: begin
        if (wd_hit)             state_d = S_IDLE;
        else if (aes_out_valid) state_d = S_HOLD;
      end
      S_HOLD:  if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Watchdog: cleared on the way into START, counts every ARM/RUN cycle.
  always_ff @(posedge clk) begin
    if (rst)                                  wd_cnt <= '0;
    else if (launch)                          wd_cnt <= '0;
    else if (in_wait && wd_cnt != CW'(TIMEOUT)) wd_cnt <= wd_cnt + CW'(1);
  end

  // Sticky timeout flag, cleared only by the next accepted go.
  always_ff @(posedge clk) begin
    if (rst)         err_q <= 1'b0;
    else if (launch) err_q <= 1'b0;
    else if (wd_hit) err_q <= 1'b1;
  end

  // Key/state word registers; writable only while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q <= '0;
      st_q  <= '0;
    end else if (wr_en && idle) begin
      case (wr_addr)
        4'd0:    key_q[191:160] <= wr_data;
        4'd1:    key_q[159:128] <= wr_data;
        4'd2:    key_q[127:96]  <= wr_data;
        4'd3:    key_q[95:64]   <= wr_data;
        4'd4:    key_q[63:32]   <= wr_data;
        4'd5:    key_q[31:0]    <= wr_data;
        4'd6:    st_q[127:96]   <= wr_data;
        4'd7:    st_q[95:64]    <= wr_data;
        4'd8:    st_q[63:32]    <= wr_data;
        4'd9:    st_q[31:0]     <= wr_data;
        default: ;
      endcase
    end
  end

  // One-cycle notice that a write arrived while an operation was in flight.
  always_ff @(posedge clk) begin
    if (rst) drop_q <= 1'b0;
    else     drop_q <= wr_en && !idle;
  end

  // Result buffer; untouched by timeouts so the last good result survives.
  always_ff @(posedge clk) begin
    if (rst)          res_q <= '0;
    else if (capture) res_q <= aes_out;
  end

  assign aes_start = (state_q == S_START);
  assign busy      = !idle;
  assign res_valid = (state_q == S_HOLD);
  assign res_data  = res_q;
  assign err       = err_q;
  assign wr_drop   = drop_q;
  assign aes_key   = key_q;
  assign aes_state = st_q;

endmodule

// File: tb/tb_aes_192_ctrl.sv
// Testbench for aes_192_ctrl: a behavioural engine stub with the 25-count
// completion timing, a register model, and a result scoreboard.
module tb_aes_192_ctrl;

  localparam logic [191:0] FIPS_KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [3:0]   wr_addr;
  logic [31:0]  wr_data;
  logic         wr_drop;
  logic         go;
  logic         busy;
  logic         err;
  logic         res_valid;
  logic         res_ready;
  logic [127:0] res_data;
  logic         aes_start;
  logic [127:0] aes_state;
  logic [191:0] aes_key;
  logic [127:0] aes_out;
  logic         aes_out_valid;

  always #5 clk = ~clk;

  aes_192_ctrl #(.TIMEOUT(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_drop       (wr_drop),
    .go            (go),
    .busy          (busy),
    .err           (err),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .aes_start     (aes_start),
    .aes_state     (aes_state),
    .aes_key       (aes_key),
    .aes_out       (aes_out),
    .aes_out_valid (aes_out_valid)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Engine stand-in: known-answer for the FIPS-197 C.2 vector, a simple
  // keyed mix otherwise. Only the controller is under test.
  function automatic logic [127:0] cipher(input logic [191:0] k, input logic [127:0] p);
    if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
    return ({p[95:0], p[127:96]} ^ k[127:0]) + {k[191:128], k[191:128]};
  endfunction

  logic         eng_start_r = 1'b0;
  int           eng_cnt = 0;
  logic         eng_ov = 1'b1;   // stale high before the first start
  logic [127:0] eng_out = 128'hbad0bad0bad0bad0bad0bad0bad0bad0;
  logic [191:0] eng_key = '0;
  logic [127:0] eng_st = '0;
  logic         stuck = 1'b0;

  always @(posedge clk) begin
    eng_start_r <= aes_start;
    if (aes_start && !eng_start_r) begin
      eng_cnt <= 1;
      eng_ov  <= 1'b0;
      eng_key <= aes_key;
      eng_st  <= aes_state;
    end else if (eng_cnt != 0) begin
      if (eng_cnt == 25) begin
        eng_cnt <= 0;
        eng_ov  <= 1'b1;
        eng_out <= cipher(eng_key, eng_st);
      end else begin
        eng_cnt <= eng_cnt + 1;
      end
    end
  end

  assign aes_out_valid = stuck ? 1'b0 : eng_ov;
  assign aes_out       = eng_out;

  // Register model and scoreboard state.
  logic [31:0]  mkey [6];
  logic [31:0]  mst  [4];
  logic [127:0] exp_q [$];
  logic [127:0] last_exp = '0;
  int           n_start_exp = 0;
  int           n_start_seen = 0;
  int           rv_seen = 0;
  int           cyc = 0;

  function automatic logic [191:0] model_key();
    return {mkey[0], mkey[1], mkey[2], mkey[3], mkey[4], mkey[5]};
  endfunction

  function automatic logic [127:0] model_st();
    return {mst[0], mst[1], mst[2], mst[3]};
  endfunction

  // Monitor: counts start pulses and checks each handshaken result.
  always @(negedge clk) begin
    logic [127:0] e;
    if (aes_start) n_start_seen++;
    if (res_valid) rv_seen++;
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {64'd0, res_data}, 192'd0 - 1);
      end else begin
        e = exp_q.pop_front();
        check("scoreboard_res_data", {64'd0, res_data}, {64'd0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_write(input logic [3:0] a, input logic [31:0] d);
    if (a <= 4'd5)      mkey[a] = d;
    else if (a <= 4'd9) mst[a - 4'd6] = d;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    model_write(a, d);
    tick();
    wr_en = 1'b0;
    check("reg_key", aes_key, model_key());
    check("reg_state", {64'd0, aes_state}, {64'd0, model_st()});
  endtask

  task automatic write_fips();
    for (int i = 0; i < 6; i++) wr(4'(i), FIPS_KEY[191 - 32*i -: 32]);
    for (int i = 0; i < 4; i++) wr(4'(i + 6), FIPS_PT[127 - 32*i -: 32]);
  endtask

  task automatic go_op(input bit expect_res);
    go = 1'b1;
    n_start_exp++;
    if (expect_res) begin
      last_exp = cipher(model_key(), model_st());
      exp_q.push_back(last_exp);
    end
    cyc = 0;
    tick();
    go = 1'b0;
    check("start_pulse", {191'd0, aes_start}, 192'd1);
  endtask

  task automatic wait_res();
    while (!res_valid && cyc < 80) tick();
    check("res_valid_seen", {191'd0, res_valid}, 192'd1);
  endtask

  task automatic check_reset_outputs();
    check("rst_aes_start", {191'd0, aes_start}, 192'd0);
    check("rst_busy", {191'd0, busy}, 192'd0);
    check("rst_err", {191'd0, err}, 192'd0);
    check("rst_res_valid", {191'd0, res_valid}, 192'd0);
    check("rst_wr_drop", {191'd0, wr_drop}, 192'd0);
    check("rst_res_data", {64'd0, res_data}, 192'd0);
    check("rst_aes_key", aes_key, 192'd0);
    check("rst_aes_state", {64'd0, aes_state}, 192'd0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) mkey[i] = '0;
    for (int i = 0; i < 4; i++) mst[i] = '0;
  endtask

  initial begin
    int rv0;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; go = 1'b0; res_ready = 1'b0;
    model_reset();
    repeat (3) tick();
    check_reset_outputs();
    rst = 1'b0;
    tick();

    // FIPS-197 C.2 encrypt with the stale-high out_valid from the stub.
    write_fips();
    res_ready = 1'b1;
    go_op(1);
    tick();
    check("start_one_cycle", {191'd0, aes_start}, 192'd0);
    check("busy_in_arm", {191'd0, busy}, 192'd1);
    wait_res();
    check("latency_fips", 192'(cyc), 192'd28);
    check("fips_ct", {64'd0, res_data}, {64'd0, FIPS_CT});
    tick();
    check("busy_falls", {191'd0, busy}, 192'd0);

    // Backpressure, dropped write in RUN, go ignored in HOLD.
    res_ready = 1'b0;
    go_op(1);
    while (cyc < 10) tick();
    wr_en = 1'b1; wr_addr = 4'd6; wr_data = 32'hffffffff;
    tick();
    wr_en = 1'b0;
    check("wr_drop_pulse", {191'd0, wr_drop}, 192'd1);
    tick();
    check("wr_drop_clear", {191'd0, wr_drop}, 192'd0);
    check("state_word6_kept", {160'd0, aes_state[127:96]}, {160'd0, mst[0]});
    wait_res();
    check("latency_bp", 192'(cyc), 192'd28);
    for (int i = 0; i < 10; i++) begin
      go = (i == 4);
      tick();
      check("bp_valid", {191'd0, res_valid}, 192'd1);
      check("bp_data", {64'd0, res_data}, {64'd0, FIPS_CT});
    end
    res_ready = 1'b1; go = 1'b1;
    tick();
    go = 1'b0;
    check("idle_after_handshake", {191'd0, busy}, 192'd0);
    tick();
    check("no_start_from_hold_go", {191'd0, busy}, 192'd0);
    check("start_count_hold", 192'(n_start_seen), 192'(n_start_exp));

    // Back-to-back: key kept, plaintext changed; second op writes with go.
    for (int i = 0; i < 4; i++) wr(4'(i + 6), $urandom);
    go_op(1);
    wait_res();
    check("latency_b2b_1", 192'(cyc), 192'd28);
    tick();
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = $urandom;
    model_write(wr_addr, wr_data);
    go_op(1);
    wr_en = 1'b0;
    check("start_sees_write", {64'd0, aes_state}, {64'd0, model_st()});
    wait_res();
    check("latency_b2b_2", 192'(cyc), 192'd28);
    tick();
    check("start_count_b2b", 192'(n_start_seen), 192'(n_start_exp));

    // Timeout with the engine's out_valid stuck low.
    stuck = 1'b1;
    rv0 = rv_seen;
    go_op(0);
    while (busy && cyc < 200) tick();
    check("timeout_idle_cycle", 192'(cyc), 192'd66);
    check("timeout_err", {191'd0, err}, 192'd1);
    check("timeout_no_valid", 192'(rv_seen), 192'(rv0));
    check("timeout_res_kept", {64'd0, res_data}, {64'd0, last_exp});
    stuck = 1'b0;
    go_op(1);
    check("err_cleared", {191'd0, err}, 192'd0);
    wait_res();
    tick();

    // Reset in the middle of RUN, then a fresh operation.
    go_op(0);
    while (cyc < 10) tick();
    rst = 1'b1;
    tick();
    check_reset_outputs();
    model_reset();
    rst = 1'b0;
    tick();
    write_fips();
    go_op(1);
    wait_res();
    check("latency_after_rst", 192'(cyc), 192'd28);
    check("fips_after_rst", {64'd0, res_data}, {64'd0, FIPS_CT});
    tick();

    // Randomized operations with random backpressure and dropped writes.
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 2) == 0)
        for (int i = 0; i < 6; i++) wr(4'(i), $urandom);
      for (int i = 0; i < int'($urandom_range(1, 5)); i++)
        wr(4'($urandom_range(6, 15)), $urandom);
      go_op(1);
      while (busy && cyc < 200) begin
        res_ready = $urandom_range(0, 1);
        wr_en     = ($urandom_range(0, 7) == 0);
        wr_addr   = 4'($urandom_range(0, 15));
        wr_data   = $urandom;
        tick();
      end
      wr_en = 1'b0;
      check("rand_done", {191'd0, busy}, 192'd0);
    end

    check("queue_drained", 192'(exp_q.size()), 192'd0);
    check("start_count_final", 192'(n_start_seen), 192'(n_start_exp));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
